// File: rtl/serial_add_pkg.sv
// serial_add_pkg: shared state type and counter sizing for the bit-serial adder sequencer.
package serial_add_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    function automatic int cnt_w(input int w);
        return $clog2(w + 1);
    endfunction
endpackage

// File: rtl/serial_add_seq.sv
// serial_add_seq: feeds operands LSB-first into a registered full_adder and collects the sum bits.
module serial_add_seq
    import serial_add_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] op_a,
    input  logic [W-1:0] op_b,
    input  logic         cin,
    output logic         fa_a,
    output logic         fa_b,
    output logic         fa_cin,
    input  logic         fa_sum,
    input  logic         fa_cout,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] result,
    output logic         cout
);
    localparam int KW = cnt_w(W);
    localparam logic [KW-1:0] K_LAST = KW'(W);
    state_t        state;
    logic [KW-1:0] k;
    logic [W-1:0]  a_sh, b_sh;
    logic          cin_l, run, last;
    assign run    = state == RUN;
    assign last   = k == K_LAST;
    // shift registers are empty by k = W, so the operand bits fall to 0 on their own
    assign fa_a   = run & a_sh[0];
    assign fa_b   = run & b_sh[0];
    assign fa_cin = run & ~last & ((k == '0) ? cin_l : fa_cout);
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            result    <= '0;
            cout      <= 1'b0;
            k         <= '0;
            a_sh      <= '0;
            b_sh      <= '0;
            cin_l     <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid && in_ready) begin
                    a_sh     <= op_a;
                    b_sh     <= op_b;
                    cin_l    <= cin;
                    k        <= '0;
                    in_ready <= 1'b0;
                    state    <= RUN;
                end
                RUN: begin
                    a_sh <= a_sh >> 1;
                    b_sh <= b_sh >> 1;
                    k    <= last ? k : k + KW'(1);
                    // sum bits arrive one cycle late and are shifted in from the MSB end
                    if (k != '0) result <= (result >> 1) | (W'(fa_sum) << (W - 1));
                    if (last) begin
                        cout      <= fa_cout;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: if (out_valid && out_ready) begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
